// File: rtl/addsub_pkg.sv
// Shared FSM state type and operation mode constants for the chunked add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational WIDTH-bit adder with carry in and carry out.
module chunk_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: processes CHUNK_WIDTH bits per cycle through one shared chunk_adder.
module chunked_addsub
  import addsub_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int CHUNK_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] a,
  input  logic [OPERAND_WIDTH-1:0] b,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] res,
  output logic                     carry,
  output logic                     overflow,
  output logic                     zero
);

  localparam int NUM_CHUNKS = OPERAND_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

  if (OPERAND_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
    $error("chunked_addsub: OPERAND_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  state_t                   state, state_next;
  logic                     accept;
  logic [OPERAND_WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic                     sub_q, cin_q;
  logic [CNT_W-1:0]         cnt;
  logic                     carry_q, ovf_q, zero_q;

  logic [CHUNK_WIDTH-1:0]   op_a, op_b, sum;
  logic                     cout, msb_cin;

  chunk_adder #(.WIDTH(CHUNK_WIDTH)) u_chunk_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (cin_q),
    .sum  (sum),
    .cout (cout)
  );

  // Carry into the MSB is recovered from the sum bit, avoiding a second adder tap.
  always_comb begin
    op_a     = a_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
    op_b     = b_q[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
    if (sub_q == MODE_SUB) op_b = ~op_b;
    res_next = res_q;
    res_next[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] = sum;
    msb_cin  = sum[CHUNK_WIDTH-1] ^ op_a[CHUNK_WIDTH-1] ^ op_b[CHUNK_WIDTH-1];
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: if (cnt == LAST) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= MODE_ADD;
      cin_q   <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= sub;
      cin_q <= sub;
      cnt   <= '0;
      res_q <= '0;
    end else if (state == BUSY) begin
      res_q <= res_next;
      cin_q <= cout;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) begin
        carry_q <= cout;
        ovf_q   <= msb_cin ^ cout;
        zero_q  <= (res_next == '0);
      end
    end
  end

  assign res      = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Randomized self-checking bench: three instances (CHUNK_WIDTH 1, 8, 32) run in lockstep against an arithmetic model.
module tb_chunked_addsub;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, sub, out_ready;
  logic [W-1:0] a, b;

  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic [W-1:0] res_v       [3];
  logic         carry_v     [3];
  logic         ovf_v       [3];
  logic         zero_v      [3];

  int nch [3] = '{32, 4, 1};
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chunked_addsub #(.OPERAND_WIDTH(W), .CHUNK_WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .res(res_v[0]), .carry(carry_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]));

  chunked_addsub #(.OPERAND_WIDTH(W), .CHUNK_WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .res(res_v[1]), .carry(carry_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]));

  chunked_addsub #(.OPERAND_WIDTH(W), .CHUNK_WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .res(res_v[2]), .carry(carry_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold: cycles to keep out_ready low once the 8-bit instance is in DONE
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input int hold);
    logic [W:0]   wide;
    logic [W-1:0] e_res, snap_res;
    logic         e_carry, e_ovf, e_zero;
    logic [3:0]   snap_flags;
    int           lat [3];
    bit           ready_all;

    wide    = ts ? ({1'b0, ta} + {1'b0, ~tb} + 33'd1) : ({1'b0, ta} + {1'b0, tb});
    e_res   = wide[W-1:0];
    e_carry = wide[W];
    e_ovf   = ts ? ((ta[W-1] != tb[W-1]) && (e_res[W-1] != ta[W-1]))
                 : ((ta[W-1] == tb[W-1]) && (e_res[W-1] != ta[W-1]));
    e_zero  = (e_res == '0);

    ready_all = 1'b0;
    for (int k = 0; k < 50 && !ready_all; k++) begin
      ready_all = in_ready_v[0] && in_ready_v[1] && in_ready_v[2];
      if (!ready_all) tick();
    end
    check("idle_before_accept", 64'(ready_all), 64'd1);

    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      check("in_ready_after_accept", 64'(in_ready_v[i]), 64'd0);
      lat[i] = 0;
    end

    for (int k = 1; k <= 40; k++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (out_valid_v[i] && lat[i] == 0) lat[i] = k;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end

    for (int i = 0; i < 3; i++) begin
      check("latency", 64'(lat[i]), 64'(nch[i]));
      check("res",      64'(res_v[i]),   64'(e_res));
      check("carry",    64'(carry_v[i]), 64'(e_carry));
      check("overflow", 64'(ovf_v[i]),   64'(e_ovf));
      check("zero",     64'(zero_v[i]),  64'(e_zero));
    end

    snap_res   = res_v[1];
    snap_flags = {out_valid_v[1], carry_v[1], ovf_v[1], zero_v[1]};
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_res",      64'(res_v[1]), 64'(snap_res));
      check("hold_flags",    64'({out_valid_v[1], carry_v[1], ovf_v[1], zero_v[1]}), 64'(snap_flags));
      check("hold_in_ready", 64'(in_ready_v[1]), 64'd0);
    end

    // A request offered on the DONE->IDLE edge must not be taken.
    a = ta ^ 32'h5A5A_5A5A; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("release_out_valid", 64'(out_valid_v[i]), 64'd0);
      check("release_in_ready",  64'(in_ready_v[i]),  64'd1);
      check("idle_res_kept",     64'(res_v[i]),       64'(e_res));
    end
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++)
      check("no_accept_on_release", 64'(in_ready_v[i]), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready",  64'(in_ready_v[i]),  64'd1);
      check("rst_out_valid", 64'(out_valid_v[i]), 64'd0);
      check("rst_res",       64'(res_v[i]),       64'd0);
      check("rst_flags",     64'({carry_v[i], ovf_v[i], zero_v[i]}), 64'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_txn(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_txn(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
    run_txn(32'h0000_0000, 32'h0000_0001, 1'b1, 0);
    run_txn(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10);

    // Reset two BUSY cycles into an operation, with a request pending across the reset edge.
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("midrst_out_valid", 64'(out_valid_v[i]), 64'd0);
      check("midrst_in_ready",  64'(in_ready_v[i]),  64'd1);
      check("midrst_res",       64'(res_v[i]),       64'd0);
    end
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++)
      check("no_accept_in_reset", 64'(in_ready_v[i]), 64'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    run_txn(32'hCAFE_F00D, 32'h1357_9BDF, 1'b1, 0);

    for (int n = 0; n < 1000; n++)
      run_txn(32'($urandom), 32'($urandom), 1'($urandom), (n % 97 == 0) ? 3 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chunked_addsub.md
CHUNKED_ADDSUB -- requirements
Module: chunked_addsub

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 8: bits processed per cycle; must divide OPERAND_WIDTH exactly.
REQ-003 SHALL have derived localparam NUM_CHUNKS = OPERAND_WIDTH/CHUNK_WIDTH.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: block can accept a request.
REQ-008 SHALL have port a, input, OPERAND_WIDTH: first operand.
REQ-009 SHALL have port b, input, OPERAND_WIDTH: second operand.
REQ-010 SHALL have port sub, input, 1: 0 = a+b, 1 = a-b.
REQ-011 SHALL have port out_valid, output, 1: result and flags valid.
REQ-012 SHALL have port out_ready, input, 1: consumer takes result.
REQ-013 SHALL have port res, output, OPERAND_WIDTH: result, modulo 2^OPERAND_WIDTH.
REQ-014 SHALL have port carry, output, 1: final carry-out; for sub, 1 = no borrow.
REQ-015 SHALL have port overflow, output, 1: signed two's-complement overflow.
REQ-016 SHALL have port zero, output, 1: res equals 0.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-019 SHALL accept on a rising edge with in_valid&&in_ready, capturing a, b and sub, clearing the chunk counter and the result register, and moving to BUSY.
REQ-020 SHALL, in BUSY, on each edge add chunk i of a to chunk i of b (inverted when sub), with carry-in equal to the stored carry (chunk 0 carry-in = sub), write chunk i of res, store the carry-out and increment i.
REQ-021 SHALL move BUSY->DONE on the edge that processes chunk NUM_CHUNKS-1: out_valid rises exactly NUM_CHUNKS cycles after the accept edge.
REQ-022 SHALL, on that same edge, register carry = last chunk carry-out and overflow = carry-in XOR carry-out of the MSB, and set zero = (final res == 0).
REQ-023 SHALL hold res, carry, overflow and zero stable in DONE until the edge where out_ready=1, then go to IDLE.
REQ-024 SHALL NOT accept a new request on the DONE->IDLE edge; the earliest next accept is one cycle later.
REQ-025 SHALL ignore a, b, sub and in_valid outside the accept edge.
REQ-026 SHALL support CHUNK_WIDTH == OPERAND_WIDTH (one BUSY cycle) and CHUNK_WIDTH == 1.
REQ-027 SHALL keep res and all flags at their last values in IDLE until the next accept clears res.

Reset
REQ-028 SHALL, on rst_n low at any time (including mid-BUSY or DONE), enter IDLE immediately and drive in_ready=1, out_valid=0, res=0, carry=0, overflow=0, zero=0, counter=0; the in-flight operation is discarded.
REQ-029 SHALL accept no request while rst_n is low; the first accept is possible on the first edge after release.

Structure
REQ-030 SHALL place the FSM state enum and the ADD/SUB mode constants in shared package addsub_pkg.
REQ-031 SHALL use one sub-module, chunk_adder (CHUNK_WIDTH-wide, with carry in and out, combinational), instantiated once and reused per cycle.
REQ-032 SHALL fail elaboration when OPERAND_WIDTH % CHUNK_WIDTH != 0.

Verification (OPERAND_WIDTH=32, CHUNK_WIDTH=8)
REQ-033 SHALL cover add: a=0x0000_00FF, b=0x0000_0001, sub=0 -> out_valid 4 cycles after accept, res=0x0000_0100, carry=0, overflow=0, zero=0.
REQ-034 SHALL cover signed overflow: a=0x7FFF_FFFF, b=1, sub=0 -> res=0x8000_0000, overflow=1, carry=0.
REQ-035 SHALL cover subtract to zero: a=b=0x1234_5678, sub=1 -> res=0, zero=1, carry=1, overflow=0; and a=0, b=1, sub=1 -> res=0xFFFF_FFFF, carry=0.
REQ-036 SHALL cover backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; in_ready=1 one cycle after the out_ready edge.
REQ-037 SHALL cover reset: assert rst_n=0 after 2 BUSY cycles -> immediately out_valid=0, in_ready=1, res=0; a new request after release completes correctly.
REQ-038 SHALL cover a parameter sweep of CHUNK_WIDTH in {1, 8, 32} on 1000 random operands -> results match a+b / a-b mod 2^32, with latency NUM_CHUNKS.
